// File: rtl/reservation_station.sv
// Unified reservation station: buffers dispatched instructions, snoops the CDB for
// missing operands and issues the oldest operand-complete entry to the execution units.
module reservation_station #(
    parameter int DATA_WIDTH     = 32,
    parameter int ROB_ADDR_WIDTH = 5,
    parameter int NUM_ENTRIES    = 8
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic                                   dispatch_valid_i,
    output logic                                   dispatch_ready_o,
    input  logic [6:0]                             dispatch_opcode_i,
    input  logic [2:0]                             dispatch_funct3_i,
    input  logic [6:0]                             dispatch_funct7_i,
    input  logic [ROB_ADDR_WIDTH-1:0]              dispatch_rob_tag_i,
    input  logic                                   dispatch_rs1_rdy_i,
    input  logic                                   dispatch_rs2_rdy_i,
    input  logic [DATA_WIDTH-1:0]                  dispatch_rs1_val_i,
    input  logic [DATA_WIDTH-1:0]                  dispatch_rs2_val_i,
    input  logic [ROB_ADDR_WIDTH-1:0]              dispatch_rs1_tag_i,
    input  logic [ROB_ADDR_WIDTH-1:0]              dispatch_rs2_tag_i,
    input  logic                                   cdb_valid_i,
    input  logic [ROB_ADDR_WIDTH-1:0]              cdb_rob_tag_i,
    input  logic [DATA_WIDTH-1:0]                  cdb_data_i,
    output logic                                   issue_valid_o,
    input  logic                                   issue_ready_i,
    output logic [6:0]                             issue_opcode_o,
    output logic [2:0]                             issue_funct3_o,
    output logic [6:0]                             issue_funct7_o,
    output logic [DATA_WIDTH-1:0]                  issue_v_rs1_o,
    output logic [DATA_WIDTH-1:0]                  issue_v_rs2_o,
    output logic [ROB_ADDR_WIDTH-1:0]              issue_rob_tag_o,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]       occupancy_o
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int AGE_W = IDX_W + 1;
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(NUM_ENTRIES);

    typedef struct packed {
        logic                      busy;
        logic [6:0]                opcode;
        logic [2:0]                funct3;
        logic [6:0]                funct7;
        logic [ROB_ADDR_WIDTH-1:0] rob_tag;
        logic                      rs1_rdy;
        logic [ROB_ADDR_WIDTH-1:0] rs1_tag;
        logic [DATA_WIDTH-1:0]     rs1_val;
        logic                      rs2_rdy;
        logic [ROB_ADDR_WIDTH-1:0] rs2_tag;
        logic [DATA_WIDTH-1:0]     rs2_val;
        logic [AGE_W-1:0]          age;
    } entry_t;

    entry_t             entries      [NUM_ENTRIES];
    entry_t             entries_next [NUM_ENTRIES];
    entry_t             new_entry;
    logic [AGE_W-1:0]   age_ctr;
    logic [OCC_W-1:0]   occ;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [AGE_W-1:0]   sel_age;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               dispatch_fire;
    logic               issue_fire;

    // Outstanding entries never exceed NUM_ENTRIES, so the wrapped difference
    // stays below half the age range and its sign bit gives the ordering.
    function automatic logic is_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
        logic [AGE_W-1:0] diff;
        diff = a - b;
        return diff[AGE_W-1];
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries[i].busy && entries[i].rs1_rdy && entries[i].rs2_rdy) begin
                if (!sel_found || is_older(entries[i].age, sel_age)) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                    sel_age   = entries[i].age;
                end
            end
        end
    end

    // Scanning downward leaves the lowest free index as the final pick.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!entries[i].busy) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign dispatch_ready_o = !rst_i && (occ < FULL);
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o && free_found && !flush_i;
    assign issue_fire       = issue_valid_o && issue_ready_i && !flush_i;

    assign issue_valid_o    = sel_found;
    assign issue_opcode_o   = entries[sel_idx].opcode;
    assign issue_funct3_o   = entries[sel_idx].funct3;
    assign issue_funct7_o   = entries[sel_idx].funct7;
    assign issue_v_rs1_o    = entries[sel_idx].rs1_val;
    assign issue_v_rs2_o    = entries[sel_idx].rs2_val;
    assign issue_rob_tag_o  = entries[sel_idx].rob_tag;
    assign occupancy_o      = occ;

    // Incoming entry, with a same-cycle CDB match captured directly.
    always_comb begin
        new_entry         = '0;
        new_entry.busy    = 1'b1;
        new_entry.opcode  = dispatch_opcode_i;
        new_entry.funct3  = dispatch_funct3_i;
        new_entry.funct7  = dispatch_funct7_i;
        new_entry.rob_tag = dispatch_rob_tag_i;
        new_entry.age     = age_ctr;
        new_entry.rs1_rdy = dispatch_rs1_rdy_i;
        new_entry.rs1_tag = dispatch_rs1_tag_i;
        new_entry.rs1_val = dispatch_rs1_val_i;
        new_entry.rs2_rdy = dispatch_rs2_rdy_i;
        new_entry.rs2_tag = dispatch_rs2_tag_i;
        new_entry.rs2_val = dispatch_rs2_val_i;
        if (!dispatch_rs1_rdy_i && cdb_valid_i && (cdb_rob_tag_i == dispatch_rs1_tag_i)) begin
            new_entry.rs1_rdy = 1'b1;
            new_entry.rs1_val = cdb_data_i;
        end
        if (!dispatch_rs2_rdy_i && cdb_valid_i && (cdb_rob_tag_i == dispatch_rs2_tag_i)) begin
            new_entry.rs2_rdy = 1'b1;
            new_entry.rs2_val = cdb_data_i;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            entries_next[i] = entries[i];
            if (entries[i].busy && cdb_valid_i) begin
                if (!entries[i].rs1_rdy && (entries[i].rs1_tag == cdb_rob_tag_i)) begin
                    entries_next[i].rs1_rdy = 1'b1;
                    entries_next[i].rs1_val = cdb_data_i;
                end
                if (!entries[i].rs2_rdy && (entries[i].rs2_tag == cdb_rob_tag_i)) begin
                    entries_next[i].rs2_rdy = 1'b1;
                    entries_next[i].rs2_val = cdb_data_i;
                end
            end
        end
        if (issue_fire) begin
            entries_next[sel_idx].busy = 1'b0;
        end
        // The slot being issued is still busy in registered state, so it can never be free_idx.
        if (dispatch_fire) begin
            entries_next[free_idx] = new_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i].busy <= 1'b0;
            end
            age_ctr <= '0;
            occ     <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i].busy <= 1'b0;
            end
            occ <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entries[i] <= entries_next[i];
            end
            if (dispatch_fire) begin
                age_ctr <= age_ctr + AGE_W'(1);
            end
            case ({dispatch_fire, issue_fire})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: an age-ordered queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_reservation_station;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int N  = 8;

    logic          clk_i = 1'b0;
    logic          rst_i, flush_i;
    logic          dispatch_valid_i, dispatch_ready_o;
    logic [6:0]    dispatch_opcode_i, dispatch_funct7_i;
    logic [2:0]    dispatch_funct3_i;
    logic [RW-1:0] dispatch_rob_tag_i, dispatch_rs1_tag_i, dispatch_rs2_tag_i;
    logic          dispatch_rs1_rdy_i, dispatch_rs2_rdy_i;
    logic [DW-1:0] dispatch_rs1_val_i, dispatch_rs2_val_i;
    logic          cdb_valid_i;
    logic [RW-1:0] cdb_rob_tag_i;
    logic [DW-1:0] cdb_data_i;
    logic          issue_valid_o, issue_ready_i;
    logic [6:0]    issue_opcode_o, issue_funct7_o;
    logic [2:0]    issue_funct3_o;
    logic [DW-1:0] issue_v_rs1_o, issue_v_rs2_o;
    logic [RW-1:0] issue_rob_tag_o;
    logic [3:0]    occupancy_o;

    always #5 clk_i = ~clk_i;

    reservation_station #(.DATA_WIDTH(DW), .ROB_ADDR_WIDTH(RW), .NUM_ENTRIES(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
        .dispatch_opcode_i(dispatch_opcode_i), .dispatch_funct3_i(dispatch_funct3_i),
        .dispatch_funct7_i(dispatch_funct7_i), .dispatch_rob_tag_i(dispatch_rob_tag_i),
        .dispatch_rs1_rdy_i(dispatch_rs1_rdy_i), .dispatch_rs2_rdy_i(dispatch_rs2_rdy_i),
        .dispatch_rs1_val_i(dispatch_rs1_val_i), .dispatch_rs2_val_i(dispatch_rs2_val_i),
        .dispatch_rs1_tag_i(dispatch_rs1_tag_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_tag_i(cdb_rob_tag_i), .cdb_data_i(cdb_data_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_opcode_o(issue_opcode_o), .issue_funct3_o(issue_funct3_o),
        .issue_funct7_o(issue_funct7_o), .issue_v_rs1_o(issue_v_rs1_o),
        .issue_v_rs2_o(issue_v_rs2_o), .issue_rob_tag_o(issue_rob_tag_o),
        .occupancy_o(occupancy_o)
    );

    typedef struct {
        logic [6:0]    op;
        logic [2:0]    f3;
        logic [6:0]    f7;
        logic [RW-1:0] tag;
        logic          r1;
        logic [RW-1:0] t1;
        logic [DW-1:0] v1;
        logic          r2;
        logic [RW-1:0] t2;
        logic [DW-1:0] v2;
    } ment_t;

    // Queue kept in dispatch order, so the oldest ready instruction is the first ready one.
    ment_t mq[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    chk     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        int    sel;
        bit    ev;
        bit    er;
        ment_t nw;
        if (chk) begin
            sel = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
            end
            ev = (sel >= 0);
            er = !rst_i && (mq.size() < N);
            check("issue_valid", 32'(issue_valid_o), 32'(ev));
            check("occupancy", 32'(occupancy_o), 32'(mq.size()));
            check("dispatch_ready", 32'(dispatch_ready_o), 32'(er));
            if (ev) begin
                check("issue_opcode", 32'(issue_opcode_o), 32'(mq[sel].op));
                check("issue_funct3", 32'(issue_funct3_o), 32'(mq[sel].f3));
                check("issue_funct7", 32'(issue_funct7_o), 32'(mq[sel].f7));
                check("issue_rob_tag", 32'(issue_rob_tag_o), 32'(mq[sel].tag));
                check("issue_v_rs1", issue_v_rs1_o, mq[sel].v1);
                check("issue_v_rs2", issue_v_rs2_o, mq[sel].v2);
            end
            if (rst_i || flush_i) begin
                mq.delete();
            end else begin
                if (cdb_valid_i) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].r1 && mq[i].t1 == cdb_rob_tag_i) begin
                            mq[i].r1 = 1'b1;
                            mq[i].v1 = cdb_data_i;
                        end
                        if (!mq[i].r2 && mq[i].t2 == cdb_rob_tag_i) begin
                            mq[i].r2 = 1'b1;
                            mq[i].v2 = cdb_data_i;
                        end
                    end
                end
                if (ev && issue_ready_i) mq.delete(sel);
                if (dispatch_valid_i && er) begin
                    nw.op = dispatch_opcode_i;
                    nw.f3 = dispatch_funct3_i;
                    nw.f7 = dispatch_funct7_i;
                    nw.tag = dispatch_rob_tag_i;
                    nw.r1 = dispatch_rs1_rdy_i;
                    nw.t1 = dispatch_rs1_tag_i;
                    nw.v1 = dispatch_rs1_val_i;
                    nw.r2 = dispatch_rs2_rdy_i;
                    nw.t2 = dispatch_rs2_tag_i;
                    nw.v2 = dispatch_rs2_val_i;
                    if (!nw.r1 && cdb_valid_i && cdb_rob_tag_i == nw.t1) begin
                        nw.r1 = 1'b1;
                        nw.v1 = cdb_data_i;
                    end
                    if (!nw.r2 && cdb_valid_i && cdb_rob_tag_i == nw.t2) begin
                        nw.r2 = 1'b1;
                        nw.v2 = cdb_data_i;
                    end
                    mq.push_back(nw);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_dispatch(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [RW-1:0] tag,
                                input logic r1, input logic [DW-1:0] v1, input logic [RW-1:0] t1,
                                input logic r2, input logic [DW-1:0] v2, input logic [RW-1:0] t2);
        dispatch_valid_i   = 1'b1;
        dispatch_opcode_i  = op;
        dispatch_funct3_i  = f3;
        dispatch_funct7_i  = f7;
        dispatch_rob_tag_i = tag;
        dispatch_rs1_rdy_i = r1;
        dispatch_rs1_val_i = v1;
        dispatch_rs1_tag_i = t1;
        dispatch_rs2_rdy_i = r2;
        dispatch_rs2_val_i = v2;
        dispatch_rs2_tag_i = t2;
    endtask

    task automatic dispatch(input logic [6:0] op, input logic [RW-1:0] tag,
                            input logic r1, input logic [DW-1:0] v1, input logic [RW-1:0] t1,
                            input logic r2, input logic [DW-1:0] v2, input logic [RW-1:0] t2);
        set_dispatch(op, 3'd0, 7'd0, tag, r1, v1, t1, r2, v2, t2);
        tick();
        dispatch_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; issue_ready_i = 1'b0;
        dispatch_valid_i = 1'b0;
        set_dispatch(7'd0, 3'd0, 7'd0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        dispatch_valid_i = 1'b0;
        cdb_valid_i = 1'b0; cdb_rob_tag_i = '0; cdb_data_i = '0;
        tick();
        tick();
        chk = 1'b1;
        check("ready_in_reset", 32'(dispatch_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("ready_after_reset", 32'(dispatch_ready_o), 32'd1);
        check("occ_after_reset", 32'(occupancy_o), 32'd0);

        // Simple ADD, both operands ready
        issue_ready_i = 1'b1;
        dispatch(7'h33, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
        check("add_valid", 32'(issue_valid_o), 32'd1);
        check("add_rs1", issue_v_rs1_o, 32'd5);
        check("add_rs2", issue_v_rs2_o, 32'd7);
        check("add_tag", 32'(issue_rob_tag_o), 32'd3);
        check("add_occ1", 32'(occupancy_o), 32'd1);
        tick();
        check("add_occ0", 32'(occupancy_o), 32'd0);

        // CDB wakeup, then dispatch-cycle bypass
        dispatch(7'h13, 5'd4, 1'b0, 32'd0, 5'd9, 1'b1, 32'd1, 5'd0);
        check("wait_not_valid", 32'(issue_valid_o), 32'd0);
        cdb_valid_i = 1'b1; cdb_rob_tag_i = 5'd9; cdb_data_i = 32'hDEADBEEF;
        tick();
        cdb_valid_i = 1'b0;
        check("wake_valid", 32'(issue_valid_o), 32'd1);
        check("wake_rs1", issue_v_rs1_o, 32'hDEADBEEF);
        check("wake_tag", 32'(issue_rob_tag_o), 32'd4);
        tick();
        set_dispatch(7'h13, 3'd1, 7'd0, 5'd6, 1'b0, 32'd0, 5'd10, 1'b1, 32'd2, 5'd0);
        cdb_valid_i = 1'b1; cdb_rob_tag_i = 5'd10; cdb_data_i = 32'hCAFEF00D;
        tick();
        dispatch_valid_i = 1'b0; cdb_valid_i = 1'b0;
        check("bypass_valid", 32'(issue_valid_o), 32'd1);
        check("bypass_rs1", issue_v_rs1_o, 32'hCAFEF00D);
        tick();
        issue_ready_i = 1'b0;

        // Fill to capacity with entries waiting on tag 20
        for (int i = 0; i < N; i++) begin
            dispatch(7'h33, RW'(8 + i), 1'b0, 32'd0, 5'd20, 1'b1, 32'(i), 5'd0);
        end
        check("full_occ", 32'(occupancy_o), 32'd8);
        check("full_ready", 32'(dispatch_ready_o), 32'd0);
        dispatch(7'h7F, 5'd31, 1'b1, 32'd9, 5'd0, 1'b1, 32'd9, 5'd0);
        check("full_reject_occ", 32'(occupancy_o), 32'd8);
        check("full_none_ready", 32'(issue_valid_o), 32'd0);
        cdb_valid_i = 1'b1; cdb_rob_tag_i = 5'd20; cdb_data_i = 32'h1234;
        tick();
        cdb_valid_i = 1'b0;
        check("oldest_tag", 32'(issue_rob_tag_o), 32'd8);
        check("oldest_rs1", issue_v_rs1_o, 32'h1234);
        check("oldest_rs2", issue_v_rs2_o, 32'd0);
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
        check("freed_ready", 32'(dispatch_ready_o), 32'd1);
        check("freed_occ", 32'(occupancy_o), 32'd7);

        // Stall: payload must hold while ready is low
        for (int i = 0; i < 3; i++) begin
            check("hold_tag", 32'(issue_rob_tag_o), 32'd9);
            check("hold_rs2", issue_v_rs2_o, 32'd1);
            tick();
        end
        check("hold_tag_last", 32'(issue_rob_tag_o), 32'd9);
        issue_ready_i = 1'b1;
        tick();
        check("release_occ", 32'(occupancy_o), 32'd6);
        check("release_next_tag", 32'(issue_rob_tag_o), 32'd10);
        tick();
        tick();
        check("drain_occ4", 32'(occupancy_o), 32'd4);

        // Simultaneous dispatch and issue, then flush
        dispatch(7'h33, 5'd1, 1'b1, 32'd11, 5'd0, 1'b1, 32'd12, 5'd0);
        check("simul_occ", 32'(occupancy_o), 32'd4);
        issue_ready_i = 1'b0;
        dispatch(7'h33, 5'd2, 1'b1, 32'd13, 5'd0, 1'b0, 32'd0, 5'd17);
        check("pre_flush_occ", 32'(occupancy_o), 32'd5);
        flush_i = 1'b1; issue_ready_i = 1'b1;
        set_dispatch(7'h33, 3'd0, 7'd0, 5'd5, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0);
        tick();
        flush_i = 1'b0; dispatch_valid_i = 1'b0; issue_ready_i = 1'b0;
        check("flush_occ", 32'(occupancy_o), 32'd0);
        check("flush_valid", 32'(issue_valid_o), 32'd0);

        // Reset mid-stream with six entries
        for (int i = 0; i < 6; i++) begin
            dispatch(7'h03, RW'(i), (i % 2) == 0, 32'(100 + i), 5'd30, 1'b1, 32'(i), 5'd0);
        end
        check("pre_reset_occ", 32'(occupancy_o), 32'd6);
        rst_i = 1'b1;
        tick();
        check("in_reset_ready", 32'(dispatch_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("post_reset_occ", 32'(occupancy_o), 32'd0);
        check("post_reset_valid", 32'(issue_valid_o), 32'd0);
        check("post_reset_ready", 32'(dispatch_ready_o), 32'd1);

        // Mixed traffic across age wrap, checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            issue_ready_i = (i % 3) != 0;
            cdb_valid_i   = 1'b1;
            cdb_rob_tag_i = RW'(24 + ((i * 2) % 3));
            cdb_data_i    = 32'h5000 + 32'(i);
            set_dispatch(7'(i + 1), 3'(i), 7'(i * 3), RW'(i % 32),
                         1'b0, 32'd0, RW'(24 + (i % 3)),
                         (i % 2) == 1, 32'h700 + 32'(i), RW'(24 + ((i + 2) % 3)));
            tick();
        end
        dispatch_valid_i = 1'b0;
        issue_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cdb_rob_tag_i = RW'(24 + (i % 3));
            cdb_data_i    = 32'h9000 + 32'(i);
            tick();
        end
        cdb_valid_i = 1'b0;
        check("final_occ", 32'(occupancy_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
# reservation_station

Unified out-of-order reservation station that buffers dispatched instructions, snoops the result bus (CDB) for outstanding source operands, and issues operand-complete instructions to the execution-unit cluster. It sits between rename/dispatch and the execution units. It is the initiator of the issue valid/ready handshake and a consumer of the single CDB result stream those units produce.

## Interface
- DATA_WIDTH, 32, operand and result width
- ROB_ADDR_WIDTH, 5, ROB tag width
- NUM_ENTRIES, 8, buffer depth (power of two, ≥2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  1  discard all entries (pipeline flush)
- dispatch_valid_i  in  1  dispatch request
- dispatch_ready_o  out  1  entry available
- dispatch_opcode_i  in  7  opcode
- dispatch_funct3_i  in  3  funct3
- dispatch_funct7_i  in  7  funct7
- dispatch_rob_tag_i  in  ROB_ADDR_WIDTH  destination ROB tag
- dispatch_rs1_rdy_i / dispatch_rs2_rdy_i  in  1 each  operand value already valid
- dispatch_rs1_val_i / dispatch_rs2_val_i  in  DATA_WIDTH each  operand value (used when rdy)
- dispatch_rs1_tag_i / dispatch_rs2_tag_i  in  ROB_ADDR_WIDTH each  producer tag (used when not rdy)
- cdb_valid_i  in  1  result broadcast valid
- cdb_rob_tag_i  in  ROB_ADDR_WIDTH  producing tag
- cdb_data_i  in  DATA_WIDTH  result value
- issue_valid_o  out  1  instruction offered to execution units
- issue_ready_i  in  1  execution units accept
- issue_opcode_o, issue_funct3_o, issue_funct7_o  out  7/3/7  decoded fields
- issue_v_rs1_o, issue_v_rs2_o  out  DATA_WIDTH each  operand values
- issue_rob_tag_o  out  ROB_ADDR_WIDTH  ROB tag
- occupancy_o  out  $clog2(NUM_ENTRIES+1)  valid entry count

## Operation
- Entry state: busy, opcode/funct3/funct7, rob_tag, per-source {rdy, tag, val}, age (monotonic dispatch sequence, wraps, compared modulo).
- Dispatch: accepted when dispatch_valid_i && dispatch_ready_o. Written into lowest-index free entry. dispatch_ready_o = !rst_i && occupancy (registered) < NUM_ENTRIES. A slot freed by issue this cycle is not reusable until next cycle.
- Dispatch bypass: if a source is not rdy and cdb_valid_i with cdb_rob_tag_i == that source tag in the dispatch cycle, the entry is written with rdy=1, val=cdb_data_i.
- Wakeup: every cycle, each busy entry with a non-rdy source whose tag matches a valid CDB tag sets rdy=1 and captures cdb_data_i. Both sources of one entry may wake on the same broadcast.
- Select: candidates = busy && rs1.rdy && rs2.rdy (registered state only). Issue the oldest candidate by age. issue_* outputs derive combinationally from registered entry state and never depend on issue_ready_i.
- Handshake: issue_valid_o && issue_ready_i frees the selected entry at the clock edge. Without ready, the same entry stays offered; a newly woken older entry may replace it next cycle. Payload may change only when the older entry becomes eligible.
- Occupancy: +1 on dispatch, −1 on issue, unchanged when both occur.
- Flush: flush_i clears all busy bits next edge. Dispatch and issue handshakes in the flush cycle are discarded; occupancy becomes 0.
- Reset: all busy cleared, age counter 0, occupancy_o=0, issue_valid_o=0, dispatch_ready_o=0 while rst_i high, 1 the cycle after.
- Unknown opcodes are buffered and issued unchanged (decode is the execution units' job).

## Timing
- Dispatch with both sources rdy at edge N: issue_valid_o earliest in cycle N+1.
- CDB wakeup at edge N: entry eligible in cycle N+1. There is no same-cycle CDB-to-issue forwarding.
- Dispatch-with-bypass at edge N: eligible in cycle N+1.
- Full (occupancy = NUM_ENTRIES): dispatch_ready_o=0. After an issue at edge N, ready=1 in cycle N+1.
- Age wrap: age counter width $clog2(NUM_ENTRIES)+1. Oldest compare uses wrap-aware subtraction so ordering is correct across wrap.
- Issue throughput: 1 instruction/cycle. Dispatch throughput: 1/cycle.

## Test plan
- Reset then dispatch ADD (opcode 0x33), rob_tag 3, rs1=5, rs2=7 both rdy, issue_ready_i=1 -> issue_valid_o next cycle with v_rs1=5, v_rs2=7, tag 3. occupancy returns 1→0.
- Dispatch entry with rs1 waiting on tag 9, then CDB tag 9 data 0xDEADBEEF -> issue one cycle after the broadcast with v_rs1=0xDEADBEEF. CDB in the dispatch cycle itself gives the same result via bypass.
- Fill 8 entries with waiting sources and issue_ready_i=0 -> dispatch_ready_o=0 and occupancy_o=8. Wake all on tag, issue one -> ready=1 the next cycle; the issued entry is the oldest dispatched.
- Hold issue_ready_i=0 for 3 cycles with one eligible entry -> issue_* payload stable. Raise ready -> entry freed that edge.
- Simultaneous dispatch and issue at occupancy 4 -> occupancy stays 4. flush_i with 5 entries -> occupancy 0 next cycle, issue_valid_o=0.
- Assert rst_i mid-stream with 6 entries busy -> the cycle after reset deasserts, occupancy_o=0, issue_valid_o=0, dispatch_ready_o=1.
